// File: rtl/seg7_reader_if.sv
// Decoded-event output channel of seg7_reader (valid/ready).
// Latency: none, pure wiring bundle.
// Backpressure: out_ready from the consumer holds out_* stable while low.
interface seg7_reader_if #(
   parameter int DIG_W = 2
);
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_valor;
   logic [DIG_W-1:0] out_digito;
   logic             out_erro;

   modport master (
      output out_valid, out_valor, out_digito, out_erro,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_valor, out_digito, out_erro,
      output out_ready
   );
endinterface

// File: rtl/seg7_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus; one event per stable one-hot pattern.
// Latency: pattern held from before edge 1 appears on out_* and valores after edge STABLE_CYCLES+1.
// Backpressure: out_* held while out_ready low; a new event then is dropped and sets sticky overrun.
// Build option: define SEG7_READER_ACTIVE_LOW_EN to invert segmentos/digit_sel (common-anode boards).
module seg7_reader #(
   parameter  int NUM_DIGITS    = 4,
   parameter  int STABLE_CYCLES = 4,
   localparam int DIG_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              segmentos,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   seg7_reader_if.master           out_if,
   output logic [4*NUM_DIGITS-1:0] valores,
   output logic                    overrun
);

   localparam int         SW     = NUM_DIGITS + 7;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [6:0]            seg_in;
   logic [NUM_DIGITS-1:0] sel_in;

`ifdef SEG7_READER_ACTIVE_LOW_EN
   assign seg_in = ~segmentos;
   assign sel_in = ~digit_sel;
`else
   assign seg_in = segmentos;
   assign sel_in = digit_sel;
`endif

   logic [SW-1:0]           s_q, s_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    evt_q, evt_d;
   logic                    changed;
   logic                    sel_onehot;
   state_t                  state_q, state_d;
   logic                    load, drop;
   logic [3:0]              dec_val;
   logic                    dec_err;
   logic [DIG_W-1:0]        dec_idx;
   logic [3:0]              valor_q;
   logic [DIG_W-1:0]        digito_q;
   logic                    erro_q;
   logic                    overrun_q;
   logic [4*NUM_DIGITS-1:0] valores_q;

   // Run-length tracking; the event fires only on the edge where the run first reaches STABLE
   always_comb begin
      s_d        = {sel_in, seg_in};
      changed    = (s_d != s_q);
      sel_onehot = (sel_in != '0) && ((sel_in & (sel_in - 1'b1)) == '0);
      if (changed)
         cnt_d = 8'd1;
      else if (cnt_q >= STABLE)
         cnt_d = STABLE;
      else
         cnt_d = cnt_q + 8'd1;
      evt_d = (cnt_d == STABLE) && (changed || (cnt_q != STABLE)) && sel_onehot;
   end

   // Sample register, run counter and registered event strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= '0;
         cnt_q <= '0;
         evt_q <= 1'b0;
      end else begin
         s_q   <= s_d;
         cnt_q <= cnt_d;
         evt_q <= evt_d;
      end
   end

   // Decode the segment pattern and digit index held in the sample register
   always_comb begin
      dec_err = 1'b0;
      case (s_q[6:0])
         7'b0111111: dec_val = 4'd0;
         7'b0000110: dec_val = 4'd1;
         7'b1011011: dec_val = 4'd2;
         7'b1001111: dec_val = 4'd3;
         7'b1100110: dec_val = 4'd4;
         7'b1101101: dec_val = 4'd5;
         7'b1111101: dec_val = 4'd6;
         7'b0000111: dec_val = 4'd7;
         7'b1111111: dec_val = 4'd8;
         7'b1101111: dec_val = 4'd9;
         7'b0000000: dec_val = 4'hF;
         default: begin
            dec_val = 4'hE;
            dec_err = 1'b1;
         end
      endcase
      dec_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (s_q[7+i]) dec_idx = DIG_W'(i);
   end

   // Handshake state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Handshake next state: HOLD persists until accepted with no fresh event
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (evt_q) state_d = HOLD;
         HOLD:    if (out_if.out_ready && !evt_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs: load into a free or just-accepted slot, otherwise drop
   always_comb begin
      load = evt_q && ((state_q == IDLE) || out_if.out_ready);
      drop = evt_q && (state_q == HOLD) && !out_if.out_ready;
   end

   // Output payload, overrun flag and per-digit bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valor_q   <= '0;
         digito_q  <= '0;
         erro_q    <= 1'b0;
         overrun_q <= 1'b0;
         valores_q <= '0;
      end else begin
         if (load) begin
            valor_q  <= dec_val;
            digito_q <= dec_idx;
            erro_q   <= dec_err;
         end
         if (drop) overrun_q <= 1'b1;
         if (evt_q && !dec_err) valores_q[4*dec_idx +: 4] <= dec_val;
      end
   end

   assign out_if.out_valid  = (state_q == HOLD);
   assign out_if.out_valor  = valor_q;
   assign out_if.out_digito = digito_q;
   assign out_if.out_erro   = erro_q;
   assign valores           = valores_q;
   assign overrun           = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
// Latency: n/a.
// Backpressure: drives out_ready directly per scenario.
module tb_seg7_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  segmentos = '0;
   logic [3:0]  digit_sel = '0;
   logic [15:0] valores;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;

   int         pulses;
   int         first_cyc;
   logic [3:0] cap_valor;
   logic [1:0] cap_digito;
   logic       cap_erro;

   seg7_reader_if #(.DIG_W(2)) oif ();

   seg7_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .segmentos (segmentos),
      .digit_sel (digit_sel),
      .out_if    (oif.master),
      .valores   (valores),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Apply a pattern at a negedge and observe n cycles, sampling on negedges
   task automatic run(input logic [6:0] seg, input logic [3:0] sel, input int n);
      segmentos = seg;
      digit_sel = sel;
      pulses    = 0;
      first_cyc = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (oif.out_valid === 1'b1) begin
            if (first_cyc < 0) begin
               first_cyc  = i;
               cap_valor  = oif.out_valor;
               cap_digito = oif.out_digito;
               cap_erro   = oif.out_erro;
            end
            pulses++;
         end
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (oif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", oif.out_valid); end
      n_cmp++; if (oif.out_valor !== 4'h0) begin n_bad++; $display("FAIL reset_valor got=%h exp=0", oif.out_valor); end
      n_cmp++; if (oif.out_digito !== 2'd0) begin n_bad++; $display("FAIL reset_digito got=%0d exp=0", oif.out_digito); end
      n_cmp++; if (oif.out_erro !== 1'b0) begin n_bad++; $display("FAIL reset_erro got=%b exp=0", oif.out_erro); end
      n_cmp++; if (valores !== 16'h0000) begin n_bad++; $display("FAIL reset_valores got=%h exp=0000", valores); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
   endtask

   // Digit 1 shows 2, held long: one pulse after edge 5, never re-fires
   task automatic test_decode();
      oif.out_ready = 1'b1;
      run(7'b1011011, 4'b0010, 16);
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL dec_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (first_cyc != 5) begin n_bad++; $display("FAIL dec_latency got=%0d exp=5", first_cyc); end
      n_cmp++; if (cap_valor !== 4'd2) begin n_bad++; $display("FAIL dec_valor got=%h exp=2", cap_valor); end
      n_cmp++; if (cap_digito !== 2'd1) begin n_bad++; $display("FAIL dec_digito got=%0d exp=1", cap_digito); end
      n_cmp++; if (cap_erro !== 1'b0) begin n_bad++; $display("FAIL dec_erro got=%b exp=0", cap_erro); end
      n_cmp++; if (valores !== 16'h0020) begin n_bad++; $display("FAIL dec_valores got=%h exp=0020", valores); end
   endtask

   // A 2-cycle '1' is too short; the following held '3' fires once
   task automatic test_glitch_filter();
      run(7'b0000110, 4'b0001, 2);
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL glitch_short got=%0d exp=0", pulses); end
      run(7'b1001111, 4'b0001, 10);
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (cap_valor !== 4'd3) begin n_bad++; $display("FAIL glitch_valor got=%h exp=3", cap_valor); end
      n_cmp++; if (cap_digito !== 2'd0) begin n_bad++; $display("FAIL glitch_digito got=%0d exp=0", cap_digito); end
      n_cmp++; if (valores !== 16'h0023) begin n_bad++; $display("FAIL glitch_valores got=%h exp=0023", valores); end
   endtask

   // Unknown pattern reports E with error, bank untouched
   task automatic test_invalid();
      run(7'b1110001, 4'b0100, 10);
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL inv_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (cap_valor !== 4'hE) begin n_bad++; $display("FAIL inv_valor got=%h exp=e", cap_valor); end
      n_cmp++; if (cap_erro !== 1'b1) begin n_bad++; $display("FAIL inv_erro got=%b exp=1", cap_erro); end
      n_cmp++; if (cap_digito !== 2'd2) begin n_bad++; $display("FAIL inv_digito got=%0d exp=2", cap_digito); end
      n_cmp++; if (valores !== 16'h0023) begin n_bad++; $display("FAIL inv_valores got=%h exp=0023", valores); end
   endtask

   // Stalled consumer: second event dropped from output but banked, overrun sticks
   task automatic test_overrun();
      oif.out_ready = 1'b0;
      run(7'b1101101, 4'b0001, 8);
      n_cmp++; if (oif.out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid1 got=%b exp=1", oif.out_valid); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early got=%b exp=0", overrun); end
      run(7'b1101111, 4'b1000, 8);
      n_cmp++; if (oif.out_valor !== 4'd5) begin n_bad++; $display("FAIL ovr_valor got=%h exp=5", oif.out_valor); end
      n_cmp++; if (oif.out_digito !== 2'd0) begin n_bad++; $display("FAIL ovr_digito got=%0d exp=0", oif.out_digito); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
      n_cmp++; if (valores !== 16'h9025) begin n_bad++; $display("FAIL ovr_valores got=%h exp=9025", valores); end
      oif.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (oif.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept got=%b exp=0", oif.out_valid); end
   endtask

   // Zero and multi-bit digit selects never produce events
   task automatic test_onehot();
      run(7'b1111111, 4'b0000, 10);
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL oh_zero got=%0d exp=0", pulses); end
      run(7'b1111111, 4'b0011, 10);
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL oh_multi got=%0d exp=0", pulses); end
      n_cmp++; if (valores !== 16'h9025) begin n_bad++; $display("FAIL oh_valores got=%h exp=9025", valores); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL oh_overrun got=%b exp=1", overrun); end
   endtask

   // Asynchronous reset mid-HOLD, then normal operation resumes
   task automatic test_async_reset();
      oif.out_ready = 1'b0;
      run(7'b1111111, 4'b0010, 8);
      n_cmp++; if (oif.out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_hold got=%b exp=1", oif.out_valid); end
      n_cmp++; if (valores !== 16'h9085) begin n_bad++; $display("FAIL ar_pre_valores got=%h exp=9085", valores); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (oif.out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got=%b exp=0", oif.out_valid); end
      n_cmp++; if (valores !== 16'h0000) begin n_bad++; $display("FAIL ar_valores got=%h exp=0000", valores); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ar_overrun got=%b exp=0", overrun); end
      @(negedge clk);
      rst_n = 1'b1;
      oif.out_ready = 1'b1;
      run(7'b0000111, 4'b0100, 10);
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ar_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (first_cyc != 5) begin n_bad++; $display("FAIL ar_latency got=%0d exp=5", first_cyc); end
      n_cmp++; if (cap_valor !== 4'd7) begin n_bad++; $display("FAIL ar_valor got=%h exp=7", cap_valor); end
      n_cmp++; if (valores !== 16'h0700) begin n_bad++; $display("FAIL ar_post_valores got=%h exp=0700", valores); end
   endtask

   initial begin
      oif.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_decode();
      test_glitch_filter();
      test_invalid();
      test_overrun();
      test_onehot();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Samples a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and recovers the BCD value shown on each digit. It is the inverse of the team's BCD-to-seven-segment decoder and serves as a board-level loopback checker and a front-end for reading external display drivers. Each stable pattern is decoded once and offered on a valid/ready output; a per-digit value bank is also kept.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..16)
- STABLE_CYCLES, 4, consecutive identical samples required before decoding (1..255)
- DIG_W, derived: max(1, clog2(NUM_DIGITS)), width of the digit index
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- segmentos  in  7  segment lines; bit0=a … bit6=g; active-high unless the macro below is defined
- digit_sel  in  NUM_DIGITS  one-hot digit enable
- out_ready  in  1  consumer accepts out_* this cycle
- out_valid  out  1  out_valor/out_digito/out_erro hold a decoded event
- out_valor  out  4  0–9 decoded, 4'hF blank, 4'hE invalid pattern
- out_digito  out  DIG_W  index of the set bit in digit_sel
- out_erro  out  1  pattern is neither a digit nor blank
- valores  out  4*NUM_DIGITS  last valid value per digit; digit i at [4i+3:4i]
- overrun  out  1  sticky: an event was dropped because out_valid was high and out_ready low

## Operation
- Input stage: {digit_sel, segmentos} registered every clock into sample register S.
- Run counter: if S equals the previous S, increment (saturate at STABLE_CYCLES); otherwise reset to 1.
- Event fires exactly once per stable run: on the clock where the run length first reaches STABLE_CYCLES, and only if digit_sel in S is exactly one-hot. Zero or multiple bits set: no event, counter still runs.
- Decode: 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9, 0000000→F (blank, no error); any other pattern→E with out_erro=1.
- valores: on every event with out_erro=0, the selected digit slot is updated, independent of the handshake. Blank writes F; error events leave valores unchanged.
- Handshake FSM:
  - IDLE (out_valid=0): on an event, load out_*, go to HOLD.
  - HOLD (out_valid=1): out_* stable while out_ready=0.
  - out_ready=1 with no event: go to IDLE.
  - out_ready=1 with a simultaneous event: load the new event, stay in HOLD.
  - Event with out_ready=0: the event is dropped from the output, overrun set to 1 (valores still updated).
- overrun clears only on reset.

## Timing
- Reset values: out_valid=0, out_valor=0, out_digito=0, out_erro=0, valores=0, overrun=0, S=0, counter=0, FSM=IDLE.
- Reset is asynchronous: outputs go to their reset values immediately on rst_n low, including mid-HOLD. The first sample is taken on the first rising edge after release.
- Latency: input applied and held before edge 1 → sampled at edges 1..STABLE_CYCLES → out_valid and valores update after edge STABLE_CYCLES+1.
- STABLE_CYCLES=1: every change of S produces an event after 2 edges.
- A held pattern never re-fires; a new event requires S to change, then be stable again.
- Accept occurs on a rising edge with out_valid=1 and out_ready=1. out_valid falls on that edge unless a simultaneous event reloads.

## Configuration
- SEG7_READER_ACTIVE_LOW_EN defined: segmentos and digit_sel are inverted before the sample register (common-anode boards). All decode, one-hot, and test values refer to the post-inversion logic.
- Not defined: inputs are used as-is (active-high).

## Test plan
- Reset; segmentos=1011011, digit_sel=0010 held 6 cycles, out_ready=1 → one out_valid pulse after edge 5, out_valor=2, out_digito=1, out_erro=0, valores[7:4]=2.
- segmentos=0000110 for 2 cycles, then 1001111 held (digit_sel=0001) → exactly one event, value 3, no event for the value 1.
- segmentos=1110001, digit_sel=0100 held → out_valor=E, out_erro=1, valores unchanged (0).
- out_ready=0; digit0 shows 5 (stable), then digit3 shows 9 (stable) → out_valor holds 5, overrun=1, valores[15:12]=9; raising out_ready then drops out_valid.
- digit_sel=0000, then 0011, each held 10 cycles with segmentos=1111111 → no event, valores unchanged.
- rst_n pulsed low during HOLD → out_valid, valores, and overrun are 0 immediately; normal decode resumes after release.
